// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution for B-type, JAL and JALR: condition, target, link and
// mispredict check, behind a 2-entry in-order skid buffer with perf counters.
module branch_resolve_unit #(
   parameter int XLEN  = 64,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [XLEN-1:0]  in_pc,
   input  logic [XLEN-1:0]  in_rs1_val,
   input  logic [XLEN-1:0]  in_rs2_val,
   input  logic             in_pred_taken,
   input  logic [XLEN-1:0]  in_pred_target,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_taken,
   output logic [XLEN-1:0]  out_redirect_pc,
   output logic [XLEN-1:0]  out_link,
   output logic             out_is_jump,
   output logic             out_mispredict,
   output logic             out_illegal,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   typedef struct packed {
      logic            taken;
      logic [XLEN-1:0] redirect;
      logic [XLEN-1:0] link;
      logic            is_jump;
      logic            mispredict;
      logic            illegal;
   } res_t;

   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [XLEN-1:0] imm_b, imm_j, imm_i, pc4, jalr_sum, tgt;
   logic            cond, jump, illegal, taken;
   res_t            dec;

   assign opcode   = in_inst[6:0];
   assign funct3   = in_inst[14:12];
   assign imm_b    = {{(XLEN-13){in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                      in_inst[11:8], 1'b0};
   assign imm_j    = {{(XLEN-21){in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                      in_inst[30:21], 1'b0};
   assign imm_i    = {{(XLEN-12){in_inst[31]}}, in_inst[31:20]};
   assign pc4      = in_pc + XLEN'(4);
   assign jalr_sum = in_rs1_val + imm_i;

   always_comb begin
      cond    = 1'b0;
      jump    = 1'b0;
      illegal = 1'b0;
      tgt     = '0;
      case (opcode)
         OP_BR: begin
            tgt = in_pc + imm_b;
            case (funct3)
               3'b000:  cond = (in_rs1_val == in_rs2_val);
               3'b001:  cond = (in_rs1_val != in_rs2_val);
               3'b100:  cond = ($signed(in_rs1_val) <  $signed(in_rs2_val));
               3'b101:  cond = ($signed(in_rs1_val) >= $signed(in_rs2_val));
               3'b110:  cond = (in_rs1_val <  in_rs2_val);
               3'b111:  cond = (in_rs1_val >= in_rs2_val);
               default: illegal = 1'b1;
            endcase
         end
         OP_JAL: begin
            tgt  = in_pc + imm_j;
            cond = 1'b1;
            jump = 1'b1;
         end
         OP_JALR: begin
            if (funct3 == 3'b000) begin
               tgt  = {jalr_sum[XLEN-1:1], 1'b0};
               cond = 1'b1;
               jump = 1'b1;
            end else begin
               illegal = 1'b1;
            end
         end
         default: illegal = 1'b1;
      endcase
   end

   assign taken = cond && !illegal;

   always_comb begin
      dec            = '0;
      dec.taken      = taken;
      dec.redirect   = taken ? tgt : pc4;
      dec.link       = pc4;
      dec.is_jump    = jump && !illegal;
      dec.illegal    = illegal;
      dec.mispredict = !illegal && ((taken != in_pred_taken) ||
                                    (taken && (tgt != in_pred_target)));
   end

   // Two-entry FIFO; the head entry drives out_* directly so results are registered.
   res_t       ent_q [2];
   logic       rd_ptr, wr_ptr;
   logic [1:0] count;
   logic       push, pop;

   assign in_ready  = (count != 2'd2);
   assign out_valid = (count != 2'd0);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ent_q[0] <= '0;
         ent_q[1] <= '0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         count    <= 2'd0;
      end else if (flush) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            ent_q[wr_ptr] <= dec;
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         count <= count + 2'(push) - 2'(pop);
      end
   end

   assign out_taken       = ent_q[rd_ptr].taken;
   assign out_redirect_pc = ent_q[rd_ptr].redirect;
   assign out_link        = ent_q[rd_ptr].link;
   assign out_is_jump     = ent_q[rd_ptr].is_jump;
   assign out_mispredict  = ent_q[rd_ptr].mispredict;
   assign out_illegal     = ent_q[rd_ptr].illegal;

   // A handshake in a flush cycle still counts: the consumer already took it.
   always_ff @(posedge clk) begin
      if (!rst_n || cnt_clr) begin
         br_cnt   <= '0;
         miss_cnt <= '0;
      end else if (pop) begin
         if (!out_illegal && (br_cnt != '1))     br_cnt   <= br_cnt + 1'b1;
         if (out_mispredict && (miss_cnt != '1)) miss_cnt <= miss_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed vectors, multi-cycle corner sequences
// and randomized traffic against a transaction-level reference model.
module tb_branch_resolve_unit;

   localparam int XLEN  = 64;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   localparam int K_BR   = 0;
   localparam int K_JAL  = 1;
   localparam int K_JALR = 2;
   localparam int K_ILL  = 3;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid, in_ready;
   logic [31:0]      in_inst;
   logic [XLEN-1:0]  in_pc, in_rs1_val, in_rs2_val, in_pred_target;
   logic             in_pred_taken, flush;
   logic             out_valid, out_ready, out_taken, out_is_jump, out_mispredict, out_illegal;
   logic [XLEN-1:0]  out_redirect_pc, out_link;
   logic             cnt_clr;
   logic [CNT_W-1:0] br_cnt, miss_cnt;

   branch_resolve_unit #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
      .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val),
      .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_taken(out_taken),
      .out_redirect_pc(out_redirect_pc), .out_link(out_link), .out_is_jump(out_is_jump),
      .out_mispredict(out_mispredict), .out_illegal(out_illegal),
      .cnt_clr(cnt_clr), .br_cnt(br_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              kind;
      logic [2:0]      f3;
      logic [31:0]     inst;
      logic [XLEN-1:0] pc, rs1, rs2, imm;
      logic            pt;
      logic [XLEN-1:0] ptgt;
   } txn_t;

   typedef struct {
      logic            taken;
      logic [XLEN-1:0] redirect, link;
      logic            is_jump, mispredict, illegal;
   } exp_t;

   typedef struct {
      txn_t t;
      exp_t e;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t q[$];
   exp_t cur_exp;
   int   m_br = 0, m_miss = 0;
   bit   last_acc;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
      end
   endtask

   // Reference: works from the transaction kind and the integer immediate.
   function automatic exp_t ref_model(input txn_t t);
      exp_t            e;
      logic [XLEN-1:0] target;
      logic            tk;
      tk     = 1'b0;
      target = t.pc + t.imm;
      e.illegal = (t.kind == K_ILL);
      e.is_jump = (t.kind == K_JAL) || (t.kind == K_JALR);
      case (t.kind)
         K_BR: case (t.f3)
            3'd0: tk = (t.rs1 == t.rs2);
            3'd1: tk = (t.rs1 != t.rs2);
            3'd4: tk = ($signed(t.rs1) <  $signed(t.rs2));
            3'd5: tk = ($signed(t.rs1) >= $signed(t.rs2));
            3'd6: tk = (t.rs1 <  t.rs2);
            default: tk = (t.rs1 >= t.rs2);
         endcase
         K_JAL:  tk = 1'b1;
         K_JALR: begin
            tk     = 1'b1;
            target = (t.rs1 + t.imm) & ~64'd1;
         end
         default: tk = 1'b0;
      endcase
      e.taken      = tk;
      e.link       = t.pc + 64'd4;
      e.redirect   = tk ? target : t.pc + 64'd4;
      e.mispredict = !e.illegal && ((tk != t.pt) || (tk && target != t.ptgt));
      return e;
   endfunction

   function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [63:0] imm);
      return {imm[12], imm[10:5], 5'd3, 5'd4, f3, imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_j(input logic [63:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
   endfunction
   function automatic logic [31:0] enc_jalr(input logic [2:0] f3, input logic [63:0] imm);
      return {imm[11:0], 5'd2, f3, 5'd1, 7'b1100111};
   endfunction

   function automatic txn_t mk(input int kind, input logic [2:0] f3, input logic [63:0] imm,
                               input logic [63:0] pc, input logic [63:0] rs1,
                               input logic [63:0] rs2, input logic pt, input logic [63:0] ptgt);
      txn_t t;
      t.kind = kind; t.f3 = f3; t.imm = imm; t.pc = pc; t.rs1 = rs1; t.rs2 = rs2;
      t.pt = pt; t.ptgt = ptgt;
      case (kind)
         K_BR:    t.inst = enc_b(f3, imm);
         K_JAL:   t.inst = enc_j(imm);
         K_JALR:  t.inst = enc_jalr(3'd0, imm);
         default: t.inst = 32'h0000_0013;
      endcase
      return t;
   endfunction

   task automatic drive(input txn_t t, input bit v);
      in_valid       = v;
      in_inst        = t.inst;
      in_pc          = t.pc;
      in_rs1_val     = t.rs1;
      in_rs2_val     = t.rs2;
      in_pred_taken  = t.pt;
      in_pred_target = t.ptgt;
      cur_exp        = ref_model(t);
   endtask

   task automatic gen_rand(output txn_t t);
      int          k, ii;
      logic [31:0] r;
      logic [6:0]  op;
      exp_t        e;
      k = int'($urandom_range(0, 9));
      t.pc  = {$urandom, $urandom};
      t.rs1 = ($urandom_range(0, 3) == 0) ? 64'(int'($urandom_range(0, 8)) - 4) : {$urandom, $urandom};
      t.rs2 = ($urandom_range(0, 2) == 0) ? t.rs1 : {$urandom, $urandom};
      t.f3  = 3'd0;
      r     = $urandom;
      if (k <= 5) begin
         t.kind = K_BR;
         case (k)
            0: t.f3 = 3'd0; 1: t.f3 = 3'd1; 2: t.f3 = 3'd4;
            3: t.f3 = 3'd5; 4: t.f3 = 3'd6; default: t.f3 = 3'd7;
         endcase
         ii = int'($urandom_range(0, 4095)) - 2048;
         t.imm  = 64'(longint'(ii * 2));
         t.inst = enc_b(t.f3, t.imm);
      end else if (k == 6) begin
         t.kind = K_JAL;
         ii = int'($urandom_range(0, 1048575)) - 524288;
         t.imm  = 64'(longint'(ii * 2));
         t.inst = enc_j(t.imm);
      end else if (k == 7) begin
         t.kind = K_JALR;
         ii = int'($urandom_range(0, 4095)) - 2048;
         t.imm  = 64'(longint'(ii));
         t.inst = enc_jalr(3'd0, t.imm);
      end else if (k == 8) begin
         t.kind = K_ILL;
         t.imm  = '0;
         do op = 7'($urandom_range(0, 127));
         while (op == 7'b1100011 || op == 7'b1101111 || op == 7'b1100111);
         t.inst = {r[31:7], op};
      end else begin
         t.kind = K_ILL;
         t.imm  = '0;
         if (r[0]) t.inst = {r[31:15], 2'b01, r[14], r[11:7], 7'b1100011};
         else      t.inst = {r[31:15], 3'(int'($urandom_range(1, 7))), r[11:7], 7'b1100111};
      end
      t.pt   = 1'($urandom_range(0, 1));
      t.ptgt = {$urandom, $urandom};
      e = ref_model(t);
      if ($urandom_range(0, 1) == 1) t.ptgt = e.redirect;
   endtask

   // Check against model at negedge, then advance the model across the next edge.
   task automatic cycle();
      exp_t h;
      bit   hs, acc;
      @(negedge clk);
      chk("out_valid", out_valid, q.size() > 0);
      chk("in_ready", in_ready, q.size() < 2);
      chk("br_cnt", br_cnt, m_br);
      chk("miss_cnt", miss_cnt, m_miss);
      if (q.size() > 0) begin
         h = q[0];
         chk("out_taken", out_taken, h.taken);
         chk("out_redirect_pc", out_redirect_pc, h.redirect);
         chk("out_link", out_link, h.link);
         chk("out_is_jump", out_is_jump, h.is_jump);
         chk("out_mispredict", out_mispredict, h.mispredict);
         chk("out_illegal", out_illegal, h.illegal);
      end
      hs  = (q.size() > 0) && out_ready;
      acc = in_valid && (q.size() < 2) && !flush;
      if (cnt_clr) begin
         m_br = 0; m_miss = 0;
      end else if (hs) begin
         if (!q[0].illegal && m_br < CMAX)   m_br++;
         if (q[0].mispredict && m_miss < CMAX) m_miss++;
      end
      if (flush) q.delete();
      else begin
         if (hs)  void'(q.pop_front());
         if (acc) q.push_back(cur_exp);
      end
      last_acc = acc;
      @(posedge clk);
      #1;
   endtask

   txn_t idle_t, t;
   vec_t vecs[9];
   int   sb, sm, tries;

   initial begin
      idle_t = mk(K_ILL, 3'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 64'd0);
      // BEQ taken, predicted not-taken
      vecs[0].t = mk(K_BR, 3'd0, 64'd16, 64'h1000, 64'd5, 64'd5, 1'b0, 64'd0);
      vecs[0].e = '{1'b1, 64'h1010, 64'h1004, 1'b0, 1'b1, 1'b0};
      vecs[1].t = mk(K_BR, 3'd4, 64'h40, 64'h2000, '1, 64'd1, 1'b1, 64'h2040);
      vecs[1].e = '{1'b1, 64'h2040, 64'h2004, 1'b0, 1'b0, 1'b0};
      vecs[2].t = mk(K_BR, 3'd6, 64'h40, 64'h2000, '1, 64'd1, 1'b1, 64'h2040);
      vecs[2].e = '{1'b0, 64'h2004, 64'h2004, 1'b0, 1'b1, 1'b0};
      vecs[3].t = mk(K_JALR, 3'd0, 64'd2, 64'h3000, 64'h2001, 64'd0, 1'b1, 64'h2002);
      vecs[3].e = '{1'b1, 64'h2002, 64'h3004, 1'b1, 1'b0, 1'b0};
      vecs[4].t = mk(K_JALR, 3'd0, 64'd2, 64'h3000, 64'h2001, 64'd0, 1'b1, 64'h2003);
      vecs[4].e = '{1'b1, 64'h2002, 64'h3004, 1'b1, 1'b1, 1'b0};
      vecs[5].t = mk(K_ILL, 3'd0, 64'd0, 64'h4000, 64'd7, 64'd7, 1'b1, 64'h4000);
      vecs[5].e = '{1'b0, 64'h4004, 64'h4004, 1'b0, 1'b0, 1'b1};
      vecs[6].t = mk(K_JAL, 3'd0, -64'sd8, 64'h5000, 64'd0, 64'd0, 1'b1, 64'h4FF8);
      vecs[6].e = '{1'b1, 64'h4FF8, 64'h5004, 1'b1, 1'b0, 1'b0};
      // BNE at the top of the address space: target and link wrap
      vecs[7].t = mk(K_BR, 3'd1, 64'd8, 64'hFFFF_FFFF_FFFF_FFFC, 64'd1, 64'd2, 1'b0, 64'd0);
      vecs[7].e = '{1'b1, 64'h4, 64'h0, 1'b0, 1'b1, 1'b0};
      vecs[8].t = mk(K_ILL, 3'd0, 64'd0, 64'h100, 64'd0, 64'd0, 1'b0, 64'd0);
      vecs[8].t.inst = enc_b(3'd2, 64'd8);
      vecs[8].e = '{1'b0, 64'h104, 64'h104, 1'b0, 1'b0, 1'b1};

      rst_n = 1'b0; flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b0;
      drive(idle_t, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst out_valid", out_valid, 0);
      chk("rst in_ready", in_ready, 1);
      chk("rst redirect", out_redirect_pc, 0);
      chk("rst link", out_link, 0);
      chk("rst flags", {out_taken, out_is_jump, out_mispredict, out_illegal}, 0);
      chk("rst counters", {br_cnt, miss_cnt}, 0);
      rst_n = 1'b1;

      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         drive(vecs[i].t, 1'b1);
         cycle();
         drive(idle_t, 1'b0);
         chk($sformatf("vec%0d valid", i), out_valid, 1);
         chk($sformatf("vec%0d taken", i), out_taken, vecs[i].e.taken);
         chk($sformatf("vec%0d redirect", i), out_redirect_pc, vecs[i].e.redirect);
         chk($sformatf("vec%0d link", i), out_link, vecs[i].e.link);
         chk($sformatf("vec%0d is_jump", i), out_is_jump, vecs[i].e.is_jump);
         chk($sformatf("vec%0d mispredict", i), out_mispredict, vecs[i].e.mispredict);
         chk($sformatf("vec%0d illegal", i), out_illegal, vecs[i].e.illegal);
         cycle();
      end

      // Backpressure: third request is held until a slot frees.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         gen_rand(t); drive(t, 1'b1); cycle();
         chk("bp accept", last_acc, 1);
      end
      gen_rand(t); drive(t, 1'b1);
      repeat (2) cycle();
      chk("bp in_ready low", in_ready, 0);
      chk("bp held", last_acc, 0);
      out_ready = 1'b1;
      tries = 0;
      do begin cycle(); tries++; end while (!last_acc && tries < 10);
      chk("bp third accepted", last_acc, 1);
      drive(idle_t, 1'b0);
      repeat (3) cycle();

      // Flush with both entries full and a request on the input.
      out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin gen_rand(t); drive(t, 1'b1); cycle(); end
      sb = m_br; sm = m_miss;
      gen_rand(t); drive(t, 1'b1);
      flush = 1'b1;
      cycle();
      flush = 1'b0; drive(idle_t, 1'b0);
      chk("flush out_valid", out_valid, 0);
      chk("flush in_ready", in_ready, 1);
      chk("flush br_cnt", br_cnt, sb);
      chk("flush miss_cnt", miss_cnt, sm);
      cycle();

      // Saturation: 16 mispredicting handshakes into a 4-bit counter.
      cnt_clr = 1'b1; cycle(); cnt_clr = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         drive(vecs[0].t, 1'b1);
         cycle();
      end
      drive(idle_t, 1'b0);
      cycle();
      chk("sat miss_cnt", miss_cnt, CMAX);
      chk("sat br_cnt", br_cnt, CMAX);
      drive(vecs[0].t, 1'b1); cycle();
      drive(idle_t, 1'b0); cnt_clr = 1'b1;
      cycle();
      cnt_clr = 1'b0;
      chk("clr miss_cnt", miss_cnt, 0);
      chk("clr br_cnt", br_cnt, 0);
      drive(vecs[5].t, 1'b1); cycle();
      drive(idle_t, 1'b0);
      chk("ill out_illegal", out_illegal, 1);
      cycle();
      chk("ill br_cnt", br_cnt, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         gen_rand(t);
         drive(t, $urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         cnt_clr   = ($urandom_range(0, 15) == 0);
         cycle();
      end
      drive(idle_t, 1'b0); flush = 1'b0; cnt_clr = 1'b0; out_ready = 1'b1;
      repeat (3) cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
